// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall controller: register/MD hazards, MD busy timer, stall counter
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_use_D,
    input  logic [4:0]  wa_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wa_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        stall,
    output logic        freeze,
    output logic        en_D,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        hz_rs, hz_rt, hz_md;

    // $0 is never a real dependency, so a zero source register cannot stall
    // even when an E/M instruction with no destination reports wa = 0.
    always_comb begin
        hz_rs = (rs_D != 5'd0) &&
                (((rs_D == wa_E) && (tuse_rs_D < tnew_E)) ||
                 ((rs_D == wa_M) && (tuse_rs_D < tnew_M)));
        hz_rt = (rt_D != 5'd0) &&
                (((rt_D == wa_E) && (tuse_rt_D < tnew_E)) ||
                 ((rt_D == wa_M) && (tuse_rt_D < tnew_M)));
        hz_md = md_use_D && (md_busy || md_start_E);
    end

    always_comb begin
        stall   = hz_rs || hz_rt || hz_md;
        freeze  = stall;
        en_D    = !stall;
        flush_E = stall;
        md_busy = (md_cnt_q != 4'd0);
    end

    // Loading at md_cnt == 1 lets a back-to-back MD op continue without a gap.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_E && (md_cnt_q <= 4'd1)) begin
            md_cnt_d = md_div_E ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // A new MD op while the unit is still busy would be silently dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(md_start_E && (md_cnt_q > 4'd1)));
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed self-checking bench for stall_ctrl
module tb_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, wa_E, wa_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_use_D, md_start_E, md_div_E;
    logic        stall, freeze, en_D, flush_E, md_busy;
    logic [31:0] stall_cnt;

    int checks;
    int errors;

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_use_D   (md_use_D),
        .wa_E       (wa_E),
        .tnew_E     (tnew_E),
        .wa_M       (wa_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall      (stall),
        .freeze     (freeze),
        .en_D       (en_D),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
        md_use_D = 1'b0; wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd0; tnew_M = 2'd0;
        md_start_E = 1'b0; md_div_E = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset state with all-zero inputs
        reset = 1'b1;
        rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd0; tuse_rt_D = 2'd0;
        md_use_D = 1'b0; wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd0; tnew_M = 2'd0;
        md_start_E = 1'b0; md_div_E = 1'b0;
        tick();
        tick();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_en_D", {31'd0, en_D}, 32'd1);
        check("rst_flush_E", {31'd0, flush_E}, 32'd0);
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        reset = 1'b0;
        idle_inputs();

        // Load-use: lw $8 in E, D reads $8 next cycle
        wa_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_freeze", {31'd0, freeze}, 32'd1);
        check("lu_en_D", {31'd0, en_D}, 32'd0);
        check("lu_flush_E", {31'd0, flush_E}, 32'd1);
        tick();
        wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd8; tnew_M = 2'd1;
        #1;
        check("lu_next_stall", {31'd0, stall}, 32'd0);
        check("lu_next_en_D", {31'd0, en_D}, 32'd1);
        check("lu_cnt", stall_cnt, 32'd1);
        // tuse 0 against tnew_M 1 on rt still stalls
        rs_D = 5'd0; rt_D = 5'd8; tuse_rt_D = 2'd0;
        #1;
        check("rt_m_stall", {31'd0, stall}, 32'd1);
        tick();
        check("rt_m_cnt", stall_cnt, 32'd2);

        // Zero register and unused-operand cases
        idle_inputs();
        wa_E = 5'd0; tnew_E = 2'd2; rs_D = 5'd0; tuse_rs_D = 2'd0;
        wa_M = 5'd0; tnew_M = 2'd2; rt_D = 5'd0; tuse_rt_D = 2'd0;
        #1;
        check("zero_reg", {31'd0, stall}, 32'd0);
        idle_inputs();
        wa_E = 5'd5; tnew_E = 2'd2; rs_D = 5'd5; tuse_rs_D = 2'd3;
        #1;
        check("tuse3", {31'd0, stall}, 32'd0);
        rs_D = 5'd6; tuse_rs_D = 2'd0;
        #1;
        check("no_match", {31'd0, stall}, 32'd0);
        tuse_rs_D = 2'd2; rs_D = 5'd5;
        #1;
        check("tuse_eq_tnew", {31'd0, stall}, 32'd0);
        tick();
        check("no_stall_cnt", stall_cnt, 32'd2);

        // Multiply with mflo held in D
        do_reset();
        md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
        #1;
        check("mul_t_stall", {31'd0, stall}, 32'd1);
        check("mul_t_busy", {31'd0, md_busy}, 32'd0);
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check($sformatf("mul_busy_%0d", i), {31'd0, md_busy}, 32'd1);
            check($sformatf("mul_stall_%0d", i), {31'd0, stall}, 32'd1);
            tick();
        end
        check("mul_done_busy", {31'd0, md_busy}, 32'd0);
        check("mul_done_stall", {31'd0, stall}, 32'd0);
        check("mul_cnt", stall_cnt, 32'd6);

        // Divide with an unrelated instruction in D
        do_reset();
        md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b0;
        #1;
        check("div_t_stall", {31'd0, stall}, 32'd0);
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("div_busy_%0d", i), {31'd0, md_busy}, 32'd1);
            check($sformatf("div_stall_%0d", i), {31'd0, stall}, 32'd0);
            tick();
        end
        check("div_done_busy", {31'd0, md_busy}, 32'd0);
        check("div_cnt", stall_cnt, 32'd0);

        // Back-to-back: mult then div issued in the last busy cycle
        do_reset();
        md_start_E = 1'b1; md_div_E = 1'b0;
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        md_start_E = 1'b1; md_div_E = 1'b1;
        #1;
        check("b2b_last_busy", {31'd0, md_busy}, 32'd1);
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("b2b_busy_%0d", i), {31'd0, md_busy}, 32'd1);
            tick();
        end
        check("b2b_done", {31'd0, md_busy}, 32'd0);

        // Reset in the middle of a divide with mfhi pending
        do_reset();
        md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 3; i++) tick();
        check("rmd_busy4", {31'd0, md_busy}, 32'd1);
        check("rmd_stall4", {31'd0, stall}, 32'd1);
        check("rmd_cnt4", stall_cnt, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rmd_busy", {31'd0, md_busy}, 32'd0);
        check("rmd_cnt", stall_cnt, 32'd0);
        check("rmd_stall", {31'd0, stall}, 32'd0);
        check("rmd_en_D", {31'd0, en_D}, 32'd1);

        // Stall counter wraparound
        do_reset();
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        check("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        wa_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
        tick();
        check("wrap_cnt", stall_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1);
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall controller for the five-stage MIPS core. Each cycle it decides whether the instruction in D may advance. On a stall it freezes the fetch unit's PC, holds the D pipeline register and injects a bubble into E. It also owns the multi-cycle multiply/divide busy timer and a stalled-cycle performance counter.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after div/divu leaves E

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- rs_D  input  5  rs field of D instruction
- rt_D  input  5  rt field of D instruction
- tuse_rs_D  input  2  cycles until D instruction needs rs; 3 = rs unused
- tuse_rt_D  input  2  same for rt
- md_use_D  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- wa_E  input  5  destination register of E instruction (0 = none)
- tnew_E  input  2  cycles until E result is forwardable
- wa_M  input  5  destination register of M instruction
- tnew_M  input  2  cycles until M result is forwardable
- md_start_E  input  1  E holds mult/multu/div/divu
- md_div_E  input  1  qualifies md_start_E: 1 = divide, 0 = multiply
- stall  output  1  combinational stall decision
- freeze  output  1  to fetch unit; holds PC (= stall)
- en_D  output  1  D pipeline register write enable (= ~stall)
- flush_E  output  1  clear E pipeline register to nop (= stall)
- md_busy  output  1  HI/LO unit busy
- stall_cnt  output  32  count of stalled cycles since reset

## Operation
Register hazard:
- hz_rs = (rs_D != 0) & ((rs_D == wa_E & tuse_rs_D < tnew_E) | (rs_D == wa_M & tuse_rs_D < tnew_M)). Compare unsigned 2-bit; tuse = 3 never stalls because tnew ≤ 2.
- hz_rt is identical with rt_D and tuse_rt_D.
- Register 0 never causes a stall, even when wa_E or wa_M is 0.

MD hazard:
- hz_md = md_use_D & (md_busy | md_start_E).

Stall decision:
- stall = hz_rs | hz_rt | hz_md.
- freeze, en_D and flush_E are pure combinational functions of stall.

MD timer:
- 4-bit down-counter md_cnt.
- If md_start_E is asserted and md_cnt ≤ 1, md_cnt loads DIV_CYCLES when md_div_E = 1, otherwise MULT_CYCLES.
- Else, if md_cnt != 0, md_cnt decrements by 1.
- md_busy = (md_cnt != 0).
- md_start_E asserted while md_cnt > 1 is ignored. The hazard logic makes this impossible; the verifier asserts it never occurs.
- Parameters must be 1..15.

Stall counter:
- stall_cnt increments on each clock edge where stall = 1.
- Wraps from 0xFFFFFFFF to 0.

Reset:
- md_cnt = 0 and stall_cnt = 0 on reset.
- Reset overrides any in-progress multiply/divide; md_busy drops the cycle after the reset edge.
- Outputs during/after reset are combinational from the inputs. With all-zero inputs: stall = 0, freeze = 0, en_D = 1, flush_E = 0, md_busy = 0, stall_cnt = 0.

## Timing
- Hazard outputs have zero latency: same-cycle combinational from D/E/M inputs.
- Fetch unit and D register sample freeze/en_D at the same clk edge as E samples flush_E.
- A mult in E at cycle t:
  - md_busy is 1 for cycles t+1 .. t+MULT_CYCLES and 0 at t+MULT_CYCLES+1.
  - An mfhi in D stalls at t (via md_start_E) and at t+1..t+MULT_CYCLES.
  - The mfhi advances at t+MULT_CYCLES+1.
- Back-to-back MD: a new md_start_E in the last busy cycle (md_cnt = 1) reloads without a gap.
- A stall lasting k cycles adds exactly k to stall_cnt.

## Test plan
- Load-use: lw $8 in E (wa_E = 8, tnew_E = 2), D uses rs = 8 with tuse_rs = 1 → stall = 1, en_D = 0, flush_E = 1. Next cycle (M, tnew_M = 1) → stall = 0. stall_cnt = 1.
- Zero register: wa_E = 0, tnew_E = 2, rs_D = 0, tuse = 0 → stall = 0. Also tuse_rs_D = 3 with a matching rs_D = 5 → stall = 0.
- Multiply: md_start_E = 1, md_div_E = 0 at t, mflo held in D → stall high t..t+5 (6 cycles), md_busy high t+1..t+5, stall_cnt = 6.
- Divide: md_div_E = 1 → md_busy high 10 cycles. An unrelated add in D (md_use_D = 0) never stalls.
- Reset mid-divide: assert reset at busy cycle 4 → md_busy = 0 the next cycle, stall_cnt = 0, and a pending mfhi proceeds.
- Counter wrap: force stall_cnt to 0xFFFFFFFF via hierarchical deposit, then one stall cycle → stall_cnt = 0.
